// File: rtl/rsa_if_pkg.sv
// Shared definitions for the Arm/FPGA RSA command interface: command codes,
// master FSM state encoding and default sizes.
package rsa_if_pkg;

  localparam int unsigned TxSizeDefault  = 1024;
  localparam int unsigned TimeoutDefault = 32'd16777216;

  localparam logic [2:0] CmdReadA       = 3'd0;
  localparam logic [2:0] CmdReadX       = 3'd1;
  localparam logic [2:0] CmdReadRsqmodm = 3'd2;
  localparam logic [2:0] CmdReadE       = 3'd3;
  localparam logic [2:0] CmdCompute     = 3'd4;
  localparam logic [2:0] CmdWrite       = 3'd5;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StIssue    = 4'd1;
  localparam logic [3:0] StDataOut  = 4'd2;
  localparam logic [3:0] StDataIn   = 4'd3;
  localparam logic [3:0] StWaitDone = 4'd4;
  localparam logic [3:0] StAck      = 4'd5;
  localparam logic [3:0] StWaitLow  = 4'd6;
  localparam logic [3:0] StFinish   = 4'd7;
  localparam logic [3:0] StError    = 4'd8;

  // States that block on the responder and are therefore subject to the timeout.
  function automatic logic is_wait_state(input logic [3:0] st);
    return (st == StDataOut) || (st == StDataIn) || (st == StWaitDone) || (st == StWaitLow);
  endfunction

endpackage

// File: rtl/rsa_wait_timer.sv
// Per-phase wait counter: cleared on every state change, counts while enabled,
// flags expiry once the count reaches TIMEOUT_CYCLES (never when that is 0).
module rsa_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = rsa_if_pkg::TimeoutDefault
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [31:0] count_q, count_d;

  assign expired = (TIMEOUT_CYCLES != 0) && (count_q == TIMEOUT_CYCLES);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rsa_cmd_master.sv
// In-fabric initiator for the RSA command interface: one start pulse issues
// READ_A, READ_x, READ_Rsqmodm, READ_e, COMPUTE and WRITE, capturing the result.
module rsa_cmd_master
  import rsa_if_pkg::*;
#(
  parameter int unsigned TX_SIZE        = TxSizeDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [TX_SIZE-1:0] op_A,
  input  logic [TX_SIZE-1:0] op_x,
  input  logic [TX_SIZE-1:0] op_Rsqmodm,
  input  logic [TX_SIZE-1:0] op_e,
  output logic               busy,
  output logic               seq_done,
  output logic               error,
  output logic [2:0]         err_cmd,
  output logic [TX_SIZE-1:0] result,
  output logic [31:0]        arm_to_fpga_cmd,
  output logic               arm_to_fpga_cmd_valid,
  input  logic               fpga_to_arm_done,
  output logic               fpga_to_arm_done_read,
  output logic               arm_to_fpga_data_valid,
  input  logic               arm_to_fpga_data_ready,
  output logic [TX_SIZE-1:0] arm_to_fpga_data_A,
  output logic [TX_SIZE-1:0] arm_to_fpga_data_x,
  output logic [TX_SIZE-1:0] arm_to_fpga_data_Rsqmodm,
  output logic [TX_SIZE-1:0] arm_to_fpga_data_e,
  input  logic               fpga_to_arm_data_valid,
  output logic               fpga_to_arm_data_ready,
  input  logic [TX_SIZE-1:0] fpga_to_arm_data_A
);

  logic [3:0]         state_q, state_d;
  logic [2:0]         cmd_idx_q, cmd_idx_d;
  logic [TX_SIZE-1:0] a_q, a_d, x_q, x_d, rsq_q, rsq_d, e_q, e_d;
  logic [TX_SIZE-1:0] result_q, result_d;
  logic               error_q, error_d;
  logic [2:0]         err_cmd_q, err_cmd_d;
  logic               busy_q, seq_done_q, cmd_valid_q, done_read_q, data_valid_q, in_ready_q;
  logic               expired;

  rsa_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state_d != state_q),
    .en     (is_wait_state(state_q)),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    a_d       = a_q;
    x_d       = x_q;
    rsq_d     = rsq_q;
    e_d       = e_q;
    result_d  = result_q;
    error_d   = error_q;
    err_cmd_d = err_cmd_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d       = op_A;
          x_d       = op_x;
          rsq_d     = op_Rsqmodm;
          e_d       = op_e;
          error_d   = 1'b0;
          cmd_idx_d = CmdReadA;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (cmd_idx_q <= CmdReadE) begin
          state_d = StDataOut;
        end else if (cmd_idx_q == CmdCompute) begin
          state_d = StWaitDone;
        end else begin
          state_d = StDataIn;
        end
      end
      StDataOut: begin
        if (expired) begin
          state_d = StError;
        end else if (arm_to_fpga_data_ready) begin
          state_d = StWaitDone;
        end
      end
      StDataIn: begin
        if (expired) begin
          state_d = StError;
        end else if (fpga_to_arm_data_valid) begin
          result_d = fpga_to_arm_data_A;
          state_d  = StWaitDone;
        end
      end
      StWaitDone: begin
        if (expired) begin
          state_d = StError;
        end else if (fpga_to_arm_done) begin
          state_d = StAck;
        end
      end
      StAck: state_d = StWaitLow;
      StWaitLow: begin
        // The responder's done is registered and may still read high here.
        if (expired) begin
          state_d = StError;
        end else if (!fpga_to_arm_done) begin
          if (cmd_idx_q < CmdWrite) begin
            cmd_idx_d = cmd_idx_q + 3'd1;
            state_d   = StIssue;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      StError:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (state_d == StError) begin
      error_d   = 1'b1;
      err_cmd_d = cmd_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cmd_idx_q    <= '0;
      a_q          <= '0;
      x_q          <= '0;
      rsq_q        <= '0;
      e_q          <= '0;
      result_q     <= '0;
      error_q      <= 1'b0;
      err_cmd_q    <= '0;
      busy_q       <= 1'b0;
      seq_done_q   <= 1'b0;
      cmd_valid_q  <= 1'b0;
      done_read_q  <= 1'b0;
      data_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_idx_q    <= cmd_idx_d;
      a_q          <= a_d;
      x_q          <= x_d;
      rsq_q        <= rsq_d;
      e_q          <= e_d;
      result_q     <= result_d;
      error_q      <= error_d;
      err_cmd_q    <= err_cmd_d;
      // Strobes are registered from the next state so they line up with it.
      busy_q       <= (state_d != StIdle) && (state_d != StError);
      seq_done_q   <= (state_d == StFinish);
      cmd_valid_q  <= (state_d == StIssue);
      done_read_q  <= (state_d == StAck);
      data_valid_q <= (state_d == StDataOut);
      in_ready_q   <= (state_d == StDataIn);
    end
  end

  assign busy                     = busy_q;
  assign seq_done                 = seq_done_q;
  assign error                    = error_q;
  assign err_cmd                  = err_cmd_q;
  assign result                   = result_q;
  assign arm_to_fpga_cmd          = {29'b0, cmd_idx_q};
  assign arm_to_fpga_cmd_valid    = cmd_valid_q;
  assign fpga_to_arm_done_read    = done_read_q;
  assign arm_to_fpga_data_valid   = data_valid_q;
  assign fpga_to_arm_data_ready   = in_ready_q;
  assign arm_to_fpga_data_A       = a_q;
  assign arm_to_fpga_data_x       = x_q;
  assign arm_to_fpga_data_Rsqmodm = rsq_q;
  assign arm_to_fpga_data_e       = e_q;

endmodule

// File: tb/tb_rsa_cmd_master.sv
// Self-checking bench for rsa_cmd_master: a behavioural responder with per-command
// delays, directed table vectors, a reset abort, and randomized sequences.
module tb_rsa_cmd_master;

  localparam int unsigned W  = 64;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  op_a = '0, op_x = '0, op_r = '0, op_e = '0;
  logic          busy, seq_done, error;
  logic [2:0]    err_cmd;
  logic [W-1:0]  result;
  logic [31:0]   cmd;
  logic          cmd_valid, done_read, data_valid, in_ready;
  logic          done = 1'b0, data_ready = 1'b0, in_valid = 1'b0;
  logic [W-1:0]  d_a, d_x, d_r, d_e;
  logic [W-1:0]  in_data = '0;

  rsa_cmd_master #(
    .TX_SIZE       (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .start                   (start),
    .op_A                    (op_a),
    .op_x                    (op_x),
    .op_Rsqmodm              (op_r),
    .op_e                    (op_e),
    .busy                    (busy),
    .seq_done                (seq_done),
    .error                   (error),
    .err_cmd                 (err_cmd),
    .result                  (result),
    .arm_to_fpga_cmd         (cmd),
    .arm_to_fpga_cmd_valid   (cmd_valid),
    .fpga_to_arm_done        (done),
    .fpga_to_arm_done_read   (done_read),
    .arm_to_fpga_data_valid  (data_valid),
    .arm_to_fpga_data_ready  (data_ready),
    .arm_to_fpga_data_A      (d_a),
    .arm_to_fpga_data_x      (d_x),
    .arm_to_fpga_data_Rsqmodm(d_r),
    .arm_to_fpga_data_e      (d_e),
    .fpga_to_arm_data_valid  (in_valid),
    .fpga_to_arm_data_ready  (in_ready),
    .fpga_to_arm_data_A      (in_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Responder configuration and observations
  int           data_dly[4];
  int           done_dly[6];
  int           stale[6];
  int           hang_idx;
  logic [W-1:0] rb_val;
  logic [W-1:0] exp_op[4];
  logic [W-1:0] cap[4];
  int           cmd_log[$];
  int           acks[6];
  int           dv_cycles[4];
  int           sd_cnt, excl_viol, cv_done_viol, op_viol, cmd4_cyc, cur;

  function automatic logic [W-1:0] out_op(input int i);
    case (i)
      0:       return d_a;
      1:       return d_x;
      2:       return d_r;
      default: return d_e;
    endcase
  endfunction

  initial begin : responder
    int rs, cnt;
    rs = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn || !busy) begin
        rs = 0;
        cnt = 0;
        done = 1'b0;
        data_ready = 1'b0;
        in_valid = 1'b0;
        in_data = ~rb_val;
      end else begin
        if ((int'(cmd_valid) + int'(data_valid) + int'(in_ready) + int'(done_read)) > 1)
          excl_viol++;
        if (seq_done) sd_cnt++;
        if (cmd_valid) begin
          cmd_log.push_back(int'(cmd));
          cur = (cmd < 32'd6) ? int'(cmd) : 6;
          if (done) cv_done_viol++;
          if (cur == 4) cmd4_cyc = cyc;
        end
        if (done_read && cur < 6) acks[cur]++;
        if (data_valid && cur < 4) begin
          dv_cycles[cur]++;
          if (out_op(cur) !== exp_op[cur]) op_viol++;
        end
        case (rs)
          0: if (cmd_valid) begin
            cnt = 0;
            rs = (cur < 4) ? 1 : (cur == 4) ? 3 : (cur == 5) ? 2 : 0;
          end
          1: if (data_valid) begin
            if (cnt >= data_dly[cur]) begin
              data_ready = 1'b1;
              cap[cur] = out_op(cur);
              rs = 6;
            end else cnt++;
          end
          6: begin data_ready = 1'b0; cnt = 0; rs = 3; end
          2: if (in_ready) begin in_valid = 1'b1; in_data = rb_val; rs = 7; end
          7: begin in_valid = 1'b0; in_data = ~rb_val; cnt = 0; rs = 3; end
          3: if (cur != hang_idx) begin
            if (cnt >= done_dly[cur]) begin done = 1'b1; rs = 4; end
            else cnt++;
          end
          4: if (done_read) begin
            if (stale[cur] == 0) begin done = 1'b0; rs = 0; end
            else begin cnt = stale[cur]; rs = 5; end
          end
          5: begin
            cnt--;
            if (cnt <= 0) begin done = 1'b0; rs = 0; end
          end
          default: rs = 0;
        endcase
      end
    end
  end

  task automatic clear_obs();
    cmd_log.delete();
    for (int i = 0; i < 6; i++) acks[i] = 0;
    for (int i = 0; i < 4; i++) begin dv_cycles[i] = 0; cap[i] = ~exp_op[i]; end
    sd_cnt = 0; excl_viol = 0; cv_done_viol = 0; op_viol = 0; cmd4_cyc = 0; cur = 0;
  endtask

  task automatic set_cfg(input int x_dly, input int stl, input int hang, input logic [W-1:0] rb);
    for (int i = 0; i < 4; i++) data_dly[i] = (i == 1) ? x_dly : 0;
    for (int i = 0; i < 6; i++) begin done_dly[i] = 0; stale[i] = stl; end
    hang_idx = hang;
    rb_val = rb;
  endtask

  // Runs one sequence from IDLE and checks it against the expected outcome.
  task automatic run_seq(input string tag, input int inject, input logic [W-1:0] exp_res,
                         input logic exp_err, input int exp_ncmd);
    int bad, nack, end_cyc;
    clear_obs();
    op_a = exp_op[0]; op_x = exp_op[1]; op_r = exp_op[2]; op_e = exp_op[3];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    chk({tag, "_first_cmd"}, {cmd_valid, cmd}, {1'b1, 32'd0});
    chk({tag, "_err_cleared"}, error, 0);
    for (int k = 0; k < 1000 && busy; k++) begin
      start = (k == inject);
      if (k == inject) op_a = 64'hFF;
      @(negedge clk);
    end
    start = 1'b0;
    end_cyc = cyc;
    #1;
    chk({tag, "_ends_in_bound"}, busy, 0);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_error"}, error, exp_err);
    if (exp_err) begin
      chk({tag, "_err_cmd"}, err_cmd, 4);
      chk({tag, "_busy_drop_le18"}, (end_cyc - cmd4_cyc) <= 18, 1);
    end
    chk({tag, "_seq_done_cnt"}, sd_cnt, exp_err ? 0 : 1);
    bad = (cmd_log.size() != exp_ncmd) ? 1 : 0;
    foreach (cmd_log[i]) if (cmd_log[i] != i) bad++;
    chk({tag, "_cmd_order"}, bad, 0);
    bad = 0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin nack += acks[i]; if (acks[i] > 1) bad++; end
    chk({tag, "_double_ack"}, bad, 0);
    chk({tag, "_ack_total"}, nack, exp_err ? exp_ncmd - 1 : exp_ncmd);
    bad = 0;
    for (int i = 0; i < 4; i++) if (cap[i] !== exp_op[i]) bad++;
    chk({tag, "_operands_seen"}, bad, 0);
    chk({tag, "_operands_stable"}, op_viol, 0);
    chk({tag, "_strobe_overlap"}, excl_viol, 0);
    chk({tag, "_cmd_while_done"}, cv_done_viol, 0);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a, x, r, e, rb;
    int           x_dly, stl, hang, inject;
    logic [W-1:0] exp_res;
    logic         exp_err;
    int           exp_ncmd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{"nominal",   64'h3, 64'h5, 64'h0, 64'h7, 64'hABCD, 0,  0, -1, -1, 64'hABCD, 1'b0, 6};
    tbl[1] = '{"backpress", 64'h3, 64'h5, 64'h0, 64'h7, 64'h1234, 10, 0, -1, -1, 64'h1234, 1'b0, 6};
    tbl[2] = '{"stale",     64'h3, 64'h5, 64'h0, 64'h7, 64'h5555, 0,  3, -1, -1, 64'h5555, 1'b0, 6};
    tbl[3] = '{"timeout",   64'h3, 64'h5, 64'h0, 64'h7, 64'h9999, 0,  0, 4,  -1, 64'h5555, 1'b1, 5};
    tbl[4] = '{"busystart", 64'h3, 64'h5, 64'h0, 64'h7, 64'h0077, 0,  0, -1, 20, 64'h0077, 1'b0, 6};

    set_cfg(0, 0, -1, '0);
    for (int i = 0; i < 4; i++) exp_op[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {busy, seq_done, error, cmd_valid, done_read, data_valid, in_ready}, 0);
    chk("reset_result", result, 0);
    chk("reset_operands", d_a | d_x | d_r | d_e, 0);
    chk("reset_cmd", {cmd, err_cmd}, 0);
    resetn = 1'b1;
    @(negedge clk);

    foreach (tbl[t]) begin
      exp_op[0] = tbl[t].a; exp_op[1] = tbl[t].x; exp_op[2] = tbl[t].r; exp_op[3] = tbl[t].e;
      set_cfg(tbl[t].x_dly, tbl[t].stl, tbl[t].hang, tbl[t].rb);
      run_seq(tbl[t].name, tbl[t].inject, tbl[t].exp_res, tbl[t].exp_err, tbl[t].exp_ncmd);
      if (t == 1) chk("backpress_valid_cycles", dv_cycles[1] >= 10, 1);
      if (t == 4) chk("busystart_data_A", d_a, 64'h3);
      @(negedge clk);
    end

    // Reset during DATA_OUT aborts the sequence on the next cycle.
    set_cfg(5, 0, -1, 64'h4242);
    clear_obs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !data_valid; k++) @(negedge clk);
    chk("rstmid_reached_data_out", data_valid, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rstmid_strobes", {busy, seq_done, error, cmd_valid, done_read, data_valid, in_ready}, 0);
    chk("rstmid_result", result, 0);
    chk("rstmid_operands", d_a | d_x | d_r | d_e, 0);
    chk("rstmid_cmd", {cmd, err_cmd}, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_stays_idle", {busy, cmd_valid, done_read}, 0);
    chk("rstmid_no_seq_done", sd_cnt, 0);

    // Randomized sequences: the model expects every operand delivered and the readback returned.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        exp_op[i] = {$urandom, $urandom};
        data_dly[i] = $urandom_range(8, 0);
      end
      for (int i = 0; i < 6; i++) begin
        done_dly[i] = $urandom_range(5, 0);
        stale[i] = $urandom_range(3, 0);
      end
      hang_idx = -1;
      rb_val = {$urandom, $urandom};
      run_seq($sformatf("rand%0d", n), -1, rb_val, 1'b0, 6);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rsa_cmd_master.md
# rsa_cmd_master

Synthesizable initiator for the Arm/FPGA RSA command interface: it drives command, data-out, data-in and done-acknowledge handshakes toward an RSA responder. One `start` pulse runs a full exponentiation: operand loads, compute, result readback. Used as the in-fabric host for standalone hardware bring-up, and as the bus-functional master in responder benches.

## Interface
- `TX_SIZE`, 1024: operand/result width.
- `TIMEOUT_CYCLES`, 2**24: per-phase wait limit; 0 disables the timeout.
- `clk` in 1: clock, all logic on the rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `start` in 1: begin a sequence; ignored while `busy`=1.
- `op_A`, `op_x`, `op_Rsqmodm`, `op_e` in TX_SIZE: operands, latched on an accepted `start`.
- `busy` out 1: sequence in progress.
- `seq_done` out 1: one-cycle pulse when `result` is valid.
- `error` out 1: sticky timeout flag; cleared by the next accepted `start`.
- `err_cmd` out 3: index of the command that timed out.
- `result` out TX_SIZE: last captured readback; held until the next capture.
- `arm_to_fpga_cmd` out 32: command code.
- `arm_to_fpga_cmd_valid` out 1: command strobe.
- `fpga_to_arm_done` in 1: responder done.
- `fpga_to_arm_done_read` out 1: done acknowledge.
- `arm_to_fpga_data_valid` out 1: outgoing data valid.
- `arm_to_fpga_data_ready` in 1: responder accepted data.
- `arm_to_fpga_data_A`, `_x`, `_Rsqmodm`, `_e` out TX_SIZE: latched operands, driven continuously.
- `fpga_to_arm_data_valid` in 1: readback valid.
- `fpga_to_arm_data_ready` out 1: master ready for readback.
- `fpga_to_arm_data_A` in TX_SIZE: readback word, captured into `result`.

## Operation
- Command codes: READ_A=0, READ_x=1, READ_Rsqmodm=2, READ_e=3, COMPUTE=4, WRITE=5.
- Commands are issued strictly in index order 0..5. A 3-bit `cmd_idx` drives `arm_to_fpga_cmd` as `{29'b0, cmd_idx}`.
- States and transitions:
  - IDLE: on `start`, latch operands, clear `error`, set `cmd_idx`=0, go to ISSUE.
  - ISSUE: `cmd_valid`=1 for exactly one cycle. Next state is DATA_OUT for idx 0–3, WAIT_DONE for idx 4, DATA_IN for idx 5.
  - DATA_OUT: `data_valid`=1 until `arm_to_fpga_data_ready` is sampled 1; then deassert and go to WAIT_DONE. Operands stay stable throughout.
  - DATA_IN: `fpga_to_arm_data_ready`=1 until `fpga_to_arm_data_valid` is sampled 1. On that edge, capture `fpga_to_arm_data_A` into `result`, then go to WAIT_DONE.
  - WAIT_DONE: wait for `fpga_to_arm_done`=1, then go to ACK.
  - ACK: `done_read`=1 for exactly one cycle, then go to WAIT_LOW.
  - WAIT_LOW: wait for `fpga_to_arm_done`=0. This guards against the responder's registered, one-cycle-late done. If idx<5, increment and go to ISSUE; else go to FINISH.
  - FINISH: `seq_done`=1 for one cycle, `busy`=0 next cycle, go to IDLE.
  - ERROR: entered from any wait state (DATA_OUT, DATA_IN, WAIT_DONE, WAIT_LOW) when its counter reaches `TIMEOUT_CYCLES`. Set `error`=1, `err_cmd`=idx, drop all strobes, go to IDLE the next cycle.
- Timeout counter clears on every state change and counts only in wait states.
- A `start` during `busy` is dropped without effect.

## Timing
- Reset: all outputs 0, `result`=0, latched operands=0, `error`=0, state IDLE. A reset mid-sequence aborts immediately with no acknowledge and no `seq_done`.
- All outputs are registered. `busy` rises the cycle after an accepted `start`, together with the first `cmd_valid`.
- Input handshake signals are sampled at the edge. A strobe deasserts in the cycle after the sampled response.
- Minimum per command: ISSUE 1 + data phase ≥1 + WAIT_DONE ≥1 + ACK 1 + WAIT_LOW ≥1 cycles.
- `done` already high on entry to WAIT_DONE: ACK follows in the next cycle.
- `done` already low on entry to WAIT_LOW: exit in one cycle.
- `cmd_valid`, `data_valid`, `fpga_to_arm_data_ready` and `done_read` are never high simultaneously.

## Structure
- Package `rsa_if_pkg`: command-code localparams, state encoding, `TX_SIZE` default (aligned with `params.vh`).
- Sub-module `rsa_wait_timer`:
  - Inputs: `clr`, `en`.
  - Output: `expired` when the count equals `TIMEOUT_CYCLES`.
  - Never expires when `TIMEOUT_CYCLES`=0.
- The top level holds the FSM, operand/result registers and `cmd_idx`.

## Test plan
- Nominal sequence:
  - Stimulus: `start` with A=0x3, x=0x5, e=0x7 (other bits 0), against a model responder that returns 0xABCD on WRITE.
  - Required: commands 0,1,2,3,4,5 in order; `result`=0xABCD; one `seq_done` pulse; `error`=0.
- Data backpressure:
  - Stimulus: responder delays `arm_to_fpga_data_ready` by 10 cycles on READ_x.
  - Required: `data_valid` held for 10+ cycles with `arm_to_fpga_data_x` stable; exactly one acknowledge for that command.
- Stale done:
  - Stimulus: responder holds `done` high 3 cycles after `done_read`.
  - Required: the next `cmd_valid` appears only after `done`=0; no double acknowledge.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=16, responder never asserts `done` after COMPUTE.
  - Required: `error`=1, `err_cmd`=4, `busy`=0 within 18 cycles; a new `start` clears `error`.
- Start while busy:
  - Stimulus: second `start` mid-sequence with A=0xFF.
  - Required: ignored; `arm_to_fpga_data_A` stays 0x3.
- Reset mid-operation:
  - Stimulus: `resetn`=0 for one cycle during DATA_OUT.
  - Required: next cycle all outputs 0, state IDLE, `result`=0.
